teclado_cajero: RTL and testbench

Keypad front-end for the `cajero` ATM controller. It captures a 4-digit PIN, a transaction type and a decimal amount from a strobed keypad. It then drives the controller's PIN digit strobe stream and its amount strobe. It sits between the keypad scanner and the ATM controller and owns the transmit side of the `digito_stb`/`digito` and `monto_stb`/`monto` interface.

---
 rtl/cajero_pkg.sv | 38 +++
 rtl/acumulador_decimal.sv | 35 +++
 rtl/teclado_cajero.sv | 206 ++++++++++++++++++++
 tb/tb_teclado_cajero.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cajero_pkg.sv
// Shared definitions for the cajero keypad front-end and ATM controller.
// Latency: none (constants, types and a pure helper function only).
// Backpressure: not applicable.
package cajero_pkg;

    // Keypad codes above the decimal digits
    localparam logic [3:0] TECLA_CLEAR    = 4'hA;
    localparam logic [3:0] TECLA_ENTER    = 4'hB;
    localparam logic [3:0] TECLA_RETIRO   = 4'hC;
    localparam logic [3:0] TECLA_DEPOSITO = 4'hD;

    // Transaction type encoding agreed with the controller
    localparam logic TIPO_DEPOSITO = 1'b0;
    localparam logic TIPO_RETIRO   = 1'b1;

    // One-hot session states
    localparam int NUM_ESTADOS = 6;
    localparam logic [NUM_ESTADOS-1:0] ST_ESPERA_TARJETA = 6'b000001;
    localparam logic [NUM_ESTADOS-1:0] ST_CAPTURA_PIN    = 6'b000010;
    localparam logic [NUM_ESTADOS-1:0] ST_ENVIO_PIN      = 6'b000100;
    localparam logic [NUM_ESTADOS-1:0] ST_ELEGIR_TIPO    = 6'b001000;
    localparam logic [NUM_ESTADOS-1:0] ST_CAPTURA_MONTO  = 6'b010000;
    localparam logic [NUM_ESTADOS-1:0] ST_ENVIO_MONTO    = 6'b100000;

    typedef enum logic [NUM_ESTADOS-1:0] {
        ESPERA_TARJETA = ST_ESPERA_TARJETA,
        CAPTURA_PIN    = ST_CAPTURA_PIN,
        ENVIO_PIN      = ST_ENVIO_PIN,
        ELEGIR_TIPO    = ST_ELEGIR_TIPO,
        CAPTURA_MONTO  = ST_CAPTURA_MONTO,
        ENVIO_MONTO    = ST_ENVIO_MONTO
    } estado_t;

    function automatic logic es_digito(input logic [3:0] t);
        return (t <= 4'd9);
    endfunction

endpackage

// File: rtl/acumulador_decimal.sv
// Decimal amount accumulator: valor = valor*10 + d per accepted digit, with a digit count.
// Latency: one cycle from clr/add to updated valor/ndig; lleno is combinational from ndig.
// Backpressure: add is ignored while lleno is high; clr has priority over add.
// Ports: clock, reset (async active-low), clr, add, d[3:0] -> valor[31:0], ndig, lleno.
module acumulador_decimal #(
    parameter  int MONTO_DIGITS = 9,
    localparam int NW           = $clog2(MONTO_DIGITS + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clr,
    input  logic          add,
    input  logic [3:0]    d,
    output logic [31:0]   valor,
    output logic [NW-1:0] ndig,
    output logic          lleno
);

    assign lleno = (ndig >= NW'(MONTO_DIGITS));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor <= '0;
            ndig  <= '0;
        end else if (clr) begin
            valor <= '0;
            ndig  <= '0;
        end else if (add && !lleno) begin
            // x10 as x8 + x2; nine decimal digits always fit in 32 bits
            valor <= (valor << 3) + (valor << 1) + {28'd0, d};
            ndig  <= ndig + NW'(1);
        end
    end

endmodule

// File: rtl/teclado_cajero.sv
// Keypad front-end for the cajero ATM: captures PIN, transaction type and amount, then strobes them out.
// Latency: key effect and tecla_rechazada one cycle after sampling; PIN digits every STB_GAP+1 cycles.
// Backpressure: none; keys arriving while busy or out of context are dropped with tecla_rechazada.
// Ports: clock, reset (async active-low), tarjeta_recibida, tecla_stb/tecla in;
//        ocupado, digito_stb/digito, tipo_trans, monto_stb/monto, tecla_rechazada out (all registered).
module teclado_cajero
    import cajero_pkg::*;
#(
    parameter int PIN_DIGITS   = 4,
    parameter int MONTO_DIGITS = 9,
    parameter int STB_GAP      = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tarjeta_recibida,
    input  logic        tecla_stb,
    input  logic [3:0]  tecla,
    output logic        ocupado,
    output logic        digito_stb,
    output logic [3:0]  digito,
    output logic        tipo_trans,
    output logic [31:0] monto,
    output logic        monto_stb,
    output logic        tecla_rechazada
);

    localparam int CW = $clog2(PIN_DIGITS + 1);
    localparam int IW = (PIN_DIGITS > 1) ? $clog2(PIN_DIGITS) : 1;
    localparam int GW = (STB_GAP > 0) ? $clog2(STB_GAP + 1) : 1;
    localparam int NW = $clog2(MONTO_DIGITS + 1);
    localparam logic [CW-1:0] PIN_LLENO = CW'(PIN_DIGITS);
    localparam logic [GW-1:0] GAP_INI   = GW'(STB_GAP);

    estado_t                    estado;
    logic [PIN_DIGITS-1:0][3:0] pin;
    logic [CW-1:0]              cnt;   // digits captured, then reused as next digit to send
    logic [GW-1:0]              gap;

    logic [31:0]   acc_valor;
    logic [NW-1:0] acc_ndig;
    logic          acc_lleno;
    logic          acc_clr;
    logic          acc_add;
    logic          abortar;
    logic          es_dig;

    // Card pulled mid-session: wins over everything else in that cycle
    assign abortar = !tarjeta_recibida && (estado != ESPERA_TARJETA);
    assign es_dig  = es_digito(tecla);

    always_comb begin
        acc_clr = abortar;
        acc_add = 1'b0;
        if (!abortar && tecla_stb) begin
            if (estado == ELEGIR_TIPO &&
                (tecla == TECLA_RETIRO || tecla == TECLA_DEPOSITO)) begin
                acc_clr = 1'b1;
            end
            if (estado == CAPTURA_MONTO) begin
                if (tecla == TECLA_CLEAR) begin
                    acc_clr = 1'b1;
                end
                if (es_dig && !acc_lleno) begin
                    acc_add = 1'b1;
                end
            end
        end
    end

    acumulador_decimal #(
        .MONTO_DIGITS (MONTO_DIGITS)
    ) u_acum (
        .clock (clock),
        .reset (reset),
        .clr   (acc_clr),
        .add   (acc_add),
        .d     (tecla),
        .valor (acc_valor),
        .ndig  (acc_ndig),
        .lleno (acc_lleno)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado          <= ESPERA_TARJETA;
            pin             <= '0;
            cnt             <= '0;
            gap             <= '0;
            ocupado         <= 1'b0;
            digito_stb      <= 1'b0;
            digito          <= '0;
            tipo_trans      <= 1'b0;
            monto           <= '0;
            monto_stb       <= 1'b0;
            tecla_rechazada <= 1'b0;
        end else begin
            digito_stb      <= 1'b0;
            monto_stb       <= 1'b0;
            tecla_rechazada <= 1'b0;

            if (abortar) begin
                // Any key in this cycle is silently discarded
                estado  <= ESPERA_TARJETA;
                ocupado <= 1'b0;
                pin     <= '0;
                cnt     <= '0;
                gap     <= '0;
            end else begin
                case (estado)
                    ESPERA_TARJETA: begin
                        tecla_rechazada <= tecla_stb;
                        if (tarjeta_recibida) begin
                            estado <= CAPTURA_PIN;
                            pin    <= '0;
                            cnt    <= '0;
                        end
                    end

                    CAPTURA_PIN: begin
                        if (tecla_stb) begin
                            if (es_dig) begin
                                if (cnt < PIN_LLENO) begin
                                    pin[cnt[IW-1:0]] <= tecla;
                                    cnt              <= cnt + CW'(1);
                                end else begin
                                    tecla_rechazada <= 1'b1;
                                end
                            end else if (tecla == TECLA_CLEAR) begin
                                cnt <= '0;
                            end else if (tecla == TECLA_ENTER && cnt == PIN_LLENO) begin
                                // First digit goes out right away; the rest are paced by gap
                                estado     <= ENVIO_PIN;
                                ocupado    <= 1'b1;
                                digito_stb <= 1'b1;
                                digito     <= pin[0];
                                cnt        <= CW'(1);
                                gap        <= GAP_INI;
                            end else begin
                                tecla_rechazada <= 1'b1;
                            end
                        end
                    end

                    ENVIO_PIN: begin
                        tecla_rechazada <= tecla_stb;
                        if (cnt == PIN_LLENO) begin
                            // Previous cycle carried the last strobe
                            estado  <= ELEGIR_TIPO;
                            ocupado <= 1'b0;
                        end else if (gap != '0) begin
                            gap <= gap - GW'(1);
                        end else begin
                            digito_stb <= 1'b1;
                            digito     <= pin[cnt[IW-1:0]];
                            cnt        <= cnt + CW'(1);
                            gap        <= GAP_INI;
                        end
                    end

                    ELEGIR_TIPO: begin
                        if (tecla_stb) begin
                            if (tecla == TECLA_RETIRO) begin
                                tipo_trans <= TIPO_RETIRO;
                                estado     <= CAPTURA_MONTO;
                            end else if (tecla == TECLA_DEPOSITO) begin
                                tipo_trans <= TIPO_DEPOSITO;
                                estado     <= CAPTURA_MONTO;
                            end else begin
                                tecla_rechazada <= 1'b1;
                            end
                        end
                    end

                    CAPTURA_MONTO: begin
                        if (tecla_stb) begin
                            if (es_dig) begin
                                tecla_rechazada <= acc_lleno;
                            end else if (tecla == TECLA_CLEAR) begin
                                tecla_rechazada <= 1'b0;
                            end else if (tecla == TECLA_ENTER && acc_ndig != '0) begin
                                estado    <= ENVIO_MONTO;
                                ocupado   <= 1'b1;
                                monto     <= acc_valor;
                                monto_stb <= 1'b1;
                            end else begin
                                tecla_rechazada <= 1'b1;
                            end
                        end
                    end

                    ENVIO_MONTO: begin
                        tecla_rechazada <= tecla_stb;
                        ocupado         <= 1'b0;
                        estado          <= ESPERA_TARJETA;
                    end

                    default: begin
                        estado  <= ESPERA_TARJETA;
                        ocupado <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_teclado_cajero.sv
// Self-checking bench for teclado_cajero: directed scenarios plus randomized sessions against a key-level model.
// Latency: bench only.
// Backpressure: bench only.
module tb_teclado_cajero;
    import cajero_pkg::*;

    localparam int GAP = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tarjeta_recibida = 1'b0;
    logic        tecla_stb = 1'b0;
    logic [3:0]  tecla = 4'd0;
    logic        ocupado;
    logic        digito_stb;
    logic [3:0]  digito;
    logic        tipo_trans;
    logic [31:0] monto;
    logic        monto_stb;
    logic        tecla_rechazada;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rej_cnt = 0;
    logic [3:0]  dig_q[$];
    int          dig_t[$];
    logic [31:0] mon_q[$];
    int          mon_t[$];
    int dig_b, mon_b, rej_b, key_e;

    teclado_cajero #(
        .PIN_DIGITS   (4),
        .MONTO_DIGITS (9),
        .STB_GAP      (GAP)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .tarjeta_recibida (tarjeta_recibida),
        .tecla_stb        (tecla_stb),
        .tecla            (tecla),
        .ocupado          (ocupado),
        .digito_stb       (digito_stb),
        .digito           (digito),
        .tipo_trans       (tipo_trans),
        .monto            (monto),
        .monto_stb        (monto_stb),
        .tecla_rechazada  (tecla_rechazada)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Output monitor: stamps each strobe with the edge that produced it
    always @(negedge clock) begin
        if (digito_stb) begin
            dig_q.push_back(digito);
            dig_t.push_back(cyc);
        end
        if (monto_stb) begin
            mon_q.push_back(monto);
            mon_t.push_back(cyc);
        end
        if (tecla_rechazada) rej_cnt++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        tecla     = k;
        tecla_stb = 1'b1;
        tick();
        key_e     = cyc;
        tecla_stb = 1'b0;
        tick();
    endtask

    task automatic mark();
        dig_b = dig_q.size();
        mon_b = mon_q.size();
        rej_b = rej_cnt;
    endtask

    task automatic start_session();
        tarjeta_recibida = 1'b1;
        tick();
    endtask

    task automatic end_session();
        tarjeta_recibida = 1'b0;
        tick();
        tick();
    endtask

    task automatic enter_pin(input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic [3:0] d);
        press(a); press(b); press(c); press(d);
        press(TECLA_ENTER);
        repeat (10) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        total++;
        if ({ocupado, digito_stb, digito, tipo_trans, monto, monto_stb, tecla_rechazada} !== '0)
            begin bad++; $display("FAIL reset_outputs got=%h want=0",
                {ocupado, digito_stb, digito, tipo_trans, monto, monto_stb, tecla_rechazada}); end
        #20;
        @(negedge clock);
        reset = 1'b1;
        tick();
        mark();
        press(4'd5);   // idle with no card: rejected
        total++;
        if (rej_cnt - rej_b != 1) begin bad++; $display("FAIL reset_idle_reject got=%0d want=1", rej_cnt - rej_b); end
        start_session();
        press(TECLA_ENTER);
        total++;
        if (rej_cnt - rej_b != 2 || dig_q.size() != dig_b)
            begin bad++; $display("FAIL reset_empty_pin rej=%0d strobes=%0d want rej=2 strobes=0",
                rej_cnt - rej_b, dig_q.size() - dig_b); end
        end_session();
    endtask

    task automatic test_deposit();
        logic [3:0] exp_d[4];
        int e0;
        exp_d = '{4'd1, 4'd2, 4'd3, 4'd4};
        mark();
        start_session();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        press(TECLA_ENTER);
        e0 = key_e;
        total++;
        if (ocupado !== 1'b1) begin bad++; $display("FAIL dep_ocupado_start got=%b want=1", ocupado); end
        repeat (5) tick();
        total++;
        if (ocupado !== 1'b1) begin bad++; $display("FAIL dep_ocupado_last got=%b want=1", ocupado); end
        tick();
        total++;
        if (ocupado !== 1'b0) begin bad++; $display("FAIL dep_ocupado_end got=%b want=0", ocupado); end
        press(TECLA_DEPOSITO);  // first cycle of ELEGIR_TIPO must accept it
        total++;
        if (dig_q.size() - dig_b != 4) begin
            bad++; $display("FAIL dep_strobe_count got=%0d want=4", dig_q.size() - dig_b);
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (dig_q[dig_b+k] !== exp_d[k] || dig_t[dig_b+k] != e0 + k*(GAP+1))
                    begin bad++; $display("FAIL dep_digit%0d got=%0d@%0d want=%0d@%0d", k,
                        dig_q[dig_b+k], dig_t[dig_b+k], exp_d[k], e0 + k*(GAP+1)); end
            end
        end
        press(4'd5); press(4'd0); press(4'd0);
        tecla = TECLA_ENTER; tecla_stb = 1'b1;
        tick();
        tecla_stb = 1'b0;
        total++;
        if (monto_stb !== 1'b1 || monto !== 32'd500 || ocupado !== 1'b1)
            begin bad++; $display("FAIL dep_monto stb=%b monto=%0d ocupado=%b want 1/500/1",
                monto_stb, monto, ocupado); end
        tick();
        total++;
        if (monto_stb !== 1'b0 || ocupado !== 1'b0 || monto !== 32'd500)
            begin bad++; $display("FAIL dep_after stb=%b ocupado=%b monto=%0d want 0/0/500",
                monto_stb, ocupado, monto); end
        total++;
        if (tipo_trans !== TIPO_DEPOSITO || rej_cnt != rej_b)
            begin bad++; $display("FAIL dep_tipo_rej tipo=%b rej=%0d want 0/0", tipo_trans, rej_cnt - rej_b); end
        end_session();
    endtask

    task automatic test_pin_clear_overflow();
        logic [3:0] exp_d[4];
        exp_d = '{4'd4, 4'd3, 4'd2, 4'd1};
        mark();
        start_session();
        press(4'd9); press(4'd9); press(TECLA_CLEAR);
        press(4'd4); press(4'd3); press(4'd2); press(4'd1);
        press(4'd7);
        total++;
        if (rej_cnt - rej_b != 1) begin bad++; $display("FAIL ovf_reject got=%0d want=1", rej_cnt - rej_b); end
        press(TECLA_ENTER);
        repeat (10) tick();
        total++;
        if (dig_q.size() - dig_b != 4) begin
            bad++; $display("FAIL ovf_strobe_count got=%0d want=4", dig_q.size() - dig_b);
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (dig_q[dig_b+k] !== exp_d[k])
                    begin bad++; $display("FAIL ovf_digit%0d got=%0d want=%0d", k, dig_q[dig_b+k], exp_d[k]); end
            end
        end
        press(TECLA_RETIRO);
        press(TECLA_ENTER);   // no amount digits yet
        total++;
        if (rej_cnt - rej_b != 2 || mon_q.size() != mon_b)
            begin bad++; $display("FAIL ovf_empty_amount rej=%0d monto_stb=%0d want 2/0",
                rej_cnt - rej_b, mon_q.size() - mon_b); end
        end_session();
    endtask

    task automatic test_early_enter();
        logic [3:0] exp_d[4];
        exp_d = '{4'd1, 4'd2, 4'd3, 4'd4};
        mark();
        start_session();
        press(4'd1); press(4'd2); press(TECLA_ENTER);
        repeat (3) tick();
        total++;
        if (rej_cnt - rej_b != 1 || dig_q.size() != dig_b || ocupado !== 1'b0)
            begin bad++; $display("FAIL early_enter rej=%0d strobes=%0d ocupado=%b want 1/0/0",
                rej_cnt - rej_b, dig_q.size() - dig_b, ocupado); end
        press(4'd3); press(4'd4); press(TECLA_ENTER);
        repeat (10) tick();
        total++;
        if (dig_q.size() - dig_b != 4) begin
            bad++; $display("FAIL early_strobe_count got=%0d want=4", dig_q.size() - dig_b);
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (dig_q[dig_b+k] !== exp_d[k])
                    begin bad++; $display("FAIL early_digit%0d got=%0d want=%0d", k, dig_q[dig_b+k], exp_d[k]); end
            end
        end
        end_session();
    endtask

    task automatic test_max_withdrawal();
        mark();
        start_session();
        enter_pin(4'd1, 4'd1, 4'd1, 4'd1);
        press(TECLA_RETIRO);
        repeat (10) press(4'd9);
        press(TECLA_ENTER);
        total++;
        if (rej_cnt - rej_b != 1) begin bad++; $display("FAIL max_reject got=%0d want=1", rej_cnt - rej_b); end
        total++;
        if (mon_q.size() - mon_b != 1) begin
            bad++; $display("FAIL max_count got=%0d want=1", mon_q.size() - mon_b);
        end else if (mon_q[mon_b] !== 32'd999999999 || mon_t[mon_b] != key_e) begin
            bad++; $display("FAIL max_monto got=%0d@%0d want=999999999@%0d", mon_q[mon_b], mon_t[mon_b], key_e);
        end
        total++;
        if (tipo_trans !== TIPO_RETIRO) begin bad++; $display("FAIL max_tipo got=%b want=1", tipo_trans); end
        end_session();
    endtask

    task automatic test_card_removal();
        mark();
        start_session();
        press(4'd5); press(4'd6); press(4'd7); press(4'd8);
        press(TECLA_ENTER);     // strobes due at key_e, +2, +4, +6
        tick();
        tick();
        tarjeta_recibida = 1'b0;  // sampled at the edge that would launch the third strobe
        tick();
        total++;
        if (ocupado !== 1'b0 || digito_stb !== 1'b0)
            begin bad++; $display("FAIL rm_outputs ocupado=%b stb=%b want 0/0", ocupado, digito_stb); end
        repeat (8) tick();
        total++;
        if (dig_q.size() - dig_b != 2) begin
            bad++; $display("FAIL rm_strobe_count got=%0d want=2", dig_q.size() - dig_b);
        end else if (dig_q[dig_b] !== 4'd5 || dig_q[dig_b+1] !== 4'd6) begin
            bad++; $display("FAIL rm_digits got=%0d,%0d want=5,6", dig_q[dig_b], dig_q[dig_b+1]);
        end
        press(4'd3);
        total++;
        if (rej_cnt - rej_b != 1) begin bad++; $display("FAIL rm_idle_reject got=%0d want=1", rej_cnt - rej_b); end
        start_session();
        press(4'd1);
        tarjeta_recibida = 1'b0;
        tecla = 4'd2; tecla_stb = 1'b1;
        tick();
        tecla_stb = 1'b0;
        total++;
        if (tecla_rechazada !== 1'b0) begin bad++; $display("FAIL rm_same_cycle got=%b want=0", tecla_rechazada); end
        tick();
        total++;
        if (rej_cnt - rej_b != 1 || dig_q.size() - dig_b != 2)
            begin bad++; $display("FAIL rm_final rej=%0d strobes=%0d want 1/2",
                rej_cnt - rej_b, dig_q.size() - dig_b); end
    endtask

    task automatic test_async_reset();
        logic [3:0] exp_d[4];
        exp_d = '{4'd9, 4'd8, 4'd7, 4'd6};
        start_session();
        enter_pin(4'd1, 4'd2, 4'd3, 4'd4);
        press(TECLA_RETIRO);
        press(4'd4); press(4'd2);
        #2 reset = 1'b0;
        #1;
        total++;
        if ({ocupado, digito_stb, digito, tipo_trans, monto, monto_stb, tecla_rechazada} !== '0)
            begin bad++; $display("FAIL arst_outputs got=%h want=0",
                {ocupado, digito_stb, digito, tipo_trans, monto, monto_stb, tecla_rechazada}); end
        #10;
        @(negedge clock);
        reset = 1'b1;
        tick();
        mark();
        press(TECLA_ENTER);   // buffer must be empty
        total++;
        if (rej_cnt - rej_b != 1 || dig_q.size() != dig_b)
            begin bad++; $display("FAIL arst_empty rej=%0d strobes=%0d want 1/0",
                rej_cnt - rej_b, dig_q.size() - dig_b); end
        enter_pin(4'd9, 4'd8, 4'd7, 4'd6);
        total++;
        if (dig_q.size() - dig_b != 4) begin
            bad++; $display("FAIL arst_strobe_count got=%0d want=4", dig_q.size() - dig_b);
        end else begin
            for (int k = 0; k < 4; k++) begin
                total++;
                if (dig_q[dig_b+k] !== exp_d[k])
                    begin bad++; $display("FAIL arst_digit%0d got=%0d want=%0d", k, dig_q[dig_b+k], exp_d[k]); end
            end
        end
        press(TECLA_DEPOSITO);
        press(4'd7);
        press(TECLA_ENTER);
        total++;
        if (mon_q.size() - mon_b != 1) begin
            bad++; $display("FAIL arst_monto_count got=%0d want=1", mon_q.size() - mon_b);
        end else if (mon_q[mon_b] !== 32'd7) begin
            bad++; $display("FAIL arst_monto got=%0d want=7", mon_q[mon_b]);
        end
        end_session();
    endtask

    // Randomized sessions; expectations come from processing the key list with plain arithmetic
    task automatic test_random();
        for (int s = 0; s < 30; s++) begin
            int          phase;
            int          pinq[$];
            int          expd[$];
            longint      amt;
            int          nd;
            int          erej;
            longint      emon[$];
            logic        etipo;
            int          r;
            logic [3:0]  k;
            phase = 0; amt = 0; nd = 0; erej = 0; etipo = 1'b0;
            pinq.delete(); expd.delete(); emon.delete();
            mark();
            start_session();
            for (int n = 0; n < 40 && phase < 3; n++) begin
                r = $urandom_range(0, 15);
                if (phase == 0 && pinq.size() == 4 && r < 6)      k = TECLA_ENTER;
                else if (phase == 1 && r < 10)                    k = (r < 5) ? TECLA_RETIRO : TECLA_DEPOSITO;
                else if (phase == 2 && nd > 0 && r < 3)           k = TECLA_ENTER;
                else if (r < 12)                                  k = 4'($urandom_range(0, 9));
                else                                              k = 4'($urandom_range(10, 15));
                case (phase)
                    0: begin
                        if (k <= 4'd9) begin
                            if (pinq.size() < 4) pinq.push_back(int'(k)); else erej++;
                        end else if (k == TECLA_CLEAR) pinq.delete();
                        else if (k == TECLA_ENTER && pinq.size() == 4) begin
                            foreach (pinq[i]) expd.push_back(pinq[i]);
                            phase = 1;
                        end else erej++;
                    end
                    1: begin
                        if (k == TECLA_RETIRO || k == TECLA_DEPOSITO) begin
                            etipo = (k == TECLA_RETIRO);
                            amt = 0; nd = 0; phase = 2;
                        end else erej++;
                    end
                    default: begin
                        if (k <= 4'd9) begin
                            if (nd < 9) begin amt = amt * 10 + longint'(k); nd++; end else erej++;
                        end else if (k == TECLA_CLEAR) begin amt = 0; nd = 0; end
                        else if (k == TECLA_ENTER && nd >= 1) begin emon.push_back(amt); phase = 3; end
                        else erej++;
                    end
                endcase
                press(k);
                if (phase == 1 && k == TECLA_ENTER) repeat (10) tick();
            end
            end_session();
            total++;
            if (dig_q.size() - dig_b != expd.size()) begin
                bad++; $display("FAIL rnd%0d_strobe_count got=%0d want=%0d", s, dig_q.size() - dig_b, expd.size());
            end else begin
                for (int i = 0; i < expd.size(); i++) begin
                    total++;
                    if (dig_q[dig_b+i] !== 4'(expd[i]))
                        begin bad++; $display("FAIL rnd%0d_digit%0d got=%0d want=%0d", s, i, dig_q[dig_b+i], expd[i]); end
                end
            end
            total++;
            if (mon_q.size() - mon_b != emon.size()) begin
                bad++; $display("FAIL rnd%0d_monto_count got=%0d want=%0d", s, mon_q.size() - mon_b, emon.size());
            end else if (emon.size() > 0) begin
                total++;
                if (mon_q[mon_b] !== 32'(emon[0]) || tipo_trans !== etipo)
                    begin bad++; $display("FAIL rnd%0d_monto got=%0d/%b want=%0d/%b", s,
                        mon_q[mon_b], tipo_trans, emon[0], etipo); end
            end
            total++;
            if (rej_cnt - rej_b != erej)
                begin bad++; $display("FAIL rnd%0d_rejects got=%0d want=%0d", s, rej_cnt - rej_b, erej); end
        end
    endtask

    initial begin
        test_reset();
        test_deposit();
        test_pin_clear_overflow();
        test_early_enter();
        test_max_withdrawal();
        test_card_removal();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
